// File: rtl/pe_in_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pe_in_sequencer (with package pe_pkg)
//  Purpose  : Feeds the PE pipeline input packet. A weight stream is written
//             into the per-lane weight buffers (LOAD). An activation-vector
//             stream is then replayed against those weights (STREAM), with
//             the final beat tagged CNN_FIN. INVALID is held while the
//             pipeline drains (DRAIN), and done pulses once at the end.
//
//  Ports    : clk, reset       - clock, asynchronous active-high reset
//             start, load_w    - start a pass (IDLE only); load weights or
//                                reuse the buffered weights
//             w_valid/w_ready  - weight stream handshake (w_data, w_mask)
//             a_valid/a_ready  - activation stream handshake (a_data)
//             pe_state, a_out  - registered PE packet fields
//             rdb_addr         - weight buffer read address
//             wrb, wrb_addr,
//             wrb_data         - weight buffer write port
//             busy, done       - pass in progress / end-of-pass pulse
//
//  Revision : 1.0 - initial release
// ============================================================================

package pe_pkg;
    // Packet qualifier consumed by the PE pipeline.
    typedef enum logic [1:0] {
        INVALID = 2'd0,
        VALID   = 2'd1,
        CNN_FIN = 2'd2
    } pe_state_t;
endpackage

module pe_in_sequencer
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WID   = 8,
    parameter int unsigned MUL_NUM    = 4,
    parameter int unsigned ADDR_B     = 4,
    parameter int unsigned KERNEL_LEN = 9,   // legal range 1 .. 2**ADDR_B
    parameter int unsigned DRAIN_CYC  = 4    // must be at least 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          load_w,
    input  logic                          w_valid,
    input  logic [DATA_WID-1:0]           w_data,
    input  logic [MUL_NUM-1:0]            w_mask,
    output logic                          w_ready,
    input  logic                          a_valid,
    input  logic [MUL_NUM*DATA_WID-1:0]   a_data,
    output logic                          a_ready,
    output pe_state_t                     pe_state,
    output logic [MUL_NUM*DATA_WID-1:0]   a_out,
    output logic [DATA_WID-1:0]           wrb_data,
    output logic [ADDR_B-1:0]             wrb_addr,
    output logic [MUL_NUM-1:0]            wrb,
    output logic [ADDR_B-1:0]             rdb_addr,
    output logic                          busy,
    output logic                          done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The tap counter is one bit wider than the buffer address so that a
    // full-depth kernel (KERNEL_LEN == 2**ADDR_B) terminates on its compare
    // value rather than relying on a wrap.
    localparam int unsigned      CNT_W    = ADDR_B + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_LEN - 1);

    // DRAIN lasts DRAIN_CYC INVALID output cycles plus the cycle that carries
    // the final beat out of the output register, so the drain counter runs
    // 0 .. DRAIN_CYC. done is registered one cycle before the exit so that it
    // is visible while the FSM is still in DRAIN (a start seen together with
    // done is therefore ignored).
    localparam int unsigned        DRN_W      = $clog2(DRAIN_CYC + 1);
    localparam logic [DRN_W-1:0]   DRN_DONE   = DRN_W'(DRAIN_CYC - 1);
    localparam logic [DRN_W-1:0]   DRN_LAST   = DRN_W'(DRAIN_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    state_t                          state_q,    state_d;
    logic [CNT_W-1:0]                cnt_q,      cnt_d;
    logic [DRN_W-1:0]                drain_q,    drain_d;
    pe_state_t                       pe_state_q, pe_state_d;
    logic [MUL_NUM*DATA_WID-1:0]     a_out_q,    a_out_d;
    logic [DATA_WID-1:0]             wrb_data_q, wrb_data_d;
    logic [ADDR_B-1:0]               wrb_addr_q, wrb_addr_d;
    logic [MUL_NUM-1:0]              wrb_q,      wrb_d;
    logic [ADDR_B-1:0]               rdb_addr_q, rdb_addr_d;
    logic                            busy_q,     busy_d;
    logic                            done_q,     done_d;

    // Ready signals decode from the state register only, so there is no
    // combinational path from either valid to either ready.
    logic in_load;
    logic in_stream;
    logic w_fire;
    logic a_fire;
    logic cnt_at_last;

    assign in_load     = (state_q == ST_LOAD);
    assign in_stream   = (state_q == ST_STREAM);
    assign w_fire      = w_valid && in_load;
    assign a_fire      = a_valid && in_stream;
    assign cnt_at_last = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Defaults: data/address fields hold, strobes and qualifiers drop.
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        a_out_d    = a_out_q;
        wrb_data_d = wrb_data_q;
        wrb_addr_d = wrb_addr_q;
        rdb_addr_d = rdb_addr_q;
        wrb_d      = '0;
        pe_state_d = INVALID;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                drain_d = '0;
                if (start) begin
                    state_d = load_w ? ST_LOAD : ST_STREAM;
                end
            end

            ST_LOAD: begin
                if (w_fire) begin
                    wrb_data_d = w_data;
                    wrb_d      = w_mask;
                    wrb_addr_d = cnt_q[ADDR_B-1:0];
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        state_d = ST_STREAM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_STREAM: begin
                if (a_fire) begin
                    a_out_d    = a_data;
                    rdb_addr_d = cnt_q[ADDR_B-1:0];
                    if (cnt_at_last) begin
                        pe_state_d = CNN_FIN;
                        cnt_d      = '0;
                        drain_d    = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        pe_state_d = VALID;
                        cnt_d      = cnt_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                a_out_d    = '0;
                rdb_addr_d = '0;
                if (drain_q == DRN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                    done_d  = (drain_q == DRN_DONE);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drain_q    <= '0;
            pe_state_q <= INVALID;
            a_out_q    <= '0;
            wrb_data_q <= '0;
            wrb_addr_q <= '0;
            wrb_q      <= '0;
            rdb_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            pe_state_q <= pe_state_d;
            a_out_q    <= a_out_d;
            wrb_data_q <= wrb_data_d;
            wrb_addr_q <= wrb_addr_d;
            wrb_q      <= wrb_d;
            rdb_addr_q <= rdb_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign w_ready  = in_load;
    assign a_ready  = in_stream;
    assign pe_state = pe_state_q;
    assign a_out    = a_out_q;
    assign wrb_data = wrb_data_q;
    assign wrb_addr = wrb_addr_q;
    assign wrb      = wrb_q;
    assign rdb_addr = rdb_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_in_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_in_sequencer
//  Purpose  : Self-checking bench for pe_in_sequencer. Directed passes cover
//             full load/stream, bubbles, weight reuse, masked/stalled load,
//             mid-pass reset and ignored starts; randomized passes follow.
//             A second instance built with KERNEL_LEN=1 covers the
//             single-tap boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_in_sequencer;
    import pe_pkg::*;

    localparam int DW = 8;
    localparam int MN = 4;
    localparam int AB = 4;
    localparam int KL = 9;
    localparam int DC = 4;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_STREAM = 2;
    localparam int P_DRAIN  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              start, load_w, w_valid, a_valid;
    logic [DW-1:0]     w_data;
    logic [MN-1:0]     w_mask;
    logic [MN*DW-1:0]  a_data;
    logic              w_ready, a_ready, busy, done;
    pe_state_t         pe_state;
    logic [MN*DW-1:0]  a_out;
    logic [DW-1:0]     wrb_data;
    logic [AB-1:0]     wrb_addr, rdb_addr;
    logic [MN-1:0]     wrb;

    pe_in_sequencer #(
        .DATA_WID(DW), .MUL_NUM(MN), .ADDR_B(AB), .KERNEL_LEN(KL), .DRAIN_CYC(DC)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .load_w(load_w),
        .w_valid(w_valid), .w_data(w_data), .w_mask(w_mask), .w_ready(w_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .pe_state(pe_state), .a_out(a_out), .wrb_data(wrb_data),
        .wrb_addr(wrb_addr), .wrb(wrb), .rdb_addr(rdb_addr),
        .busy(busy), .done(done)
    );

    // Single-tap instance
    logic              k1_start, k1_load_w, k1_w_valid, k1_a_valid;
    logic [DW-1:0]     k1_w_data;
    logic [MN-1:0]     k1_w_mask;
    logic [MN*DW-1:0]  k1_a_data;
    logic              k1_w_ready, k1_a_ready, k1_busy, k1_done;
    pe_state_t         k1_pe_state;
    logic [MN*DW-1:0]  k1_a_out;
    logic [DW-1:0]     k1_wrb_data;
    logic [AB-1:0]     k1_wrb_addr, k1_rdb_addr;
    logic [MN-1:0]     k1_wrb;

    pe_in_sequencer #(
        .DATA_WID(DW), .MUL_NUM(MN), .ADDR_B(AB), .KERNEL_LEN(1), .DRAIN_CYC(DC)
    ) u_k1 (
        .clk(clk), .reset(reset), .start(k1_start), .load_w(k1_load_w),
        .w_valid(k1_w_valid), .w_data(k1_w_data), .w_mask(k1_w_mask),
        .w_ready(k1_w_ready), .a_valid(k1_a_valid), .a_data(k1_a_data),
        .a_ready(k1_a_ready), .pe_state(k1_pe_state), .a_out(k1_a_out),
        .wrb_data(k1_wrb_data), .wrb_addr(k1_wrb_addr), .wrb(k1_wrb),
        .rdb_addr(k1_rdb_addr), .busy(k1_busy), .done(k1_done)
    );

    int n_vec     = 0;
    int n_err     = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: phase of the pass plus the packet the PE should see.
    // ------------------------------------------------------------------------
    int               ph, k, dc;
    logic [MN-1:0]    e_wrb;
    logic [DW-1:0]    e_wdata;
    logic [AB-1:0]    e_waddr;
    logic [MN*DW-1:0] e_aout;
    logic [AB-1:0]    e_rdb;
    pe_state_t        e_pe;
    logic             e_done;

    task automatic model_reset();
        ph = P_IDLE; k = 0; dc = 0;
        e_wrb = '0; e_wdata = '0; e_waddr = '0; e_aout = '0; e_rdb = '0;
        e_pe = INVALID; e_done = 1'b0;
    endtask

    task automatic compare_all();
        check("w_ready",  w_ready,  ph == P_LOAD);
        check("a_ready",  a_ready,  ph == P_STREAM);
        check("busy",     busy,     ph != P_IDLE);
        check("done",     done,     e_done);
        check("wrb",      wrb,      e_wrb);
        check("wrb_addr", wrb_addr, e_waddr);
        check("wrb_data", wrb_data, e_wdata);
        check("pe_state", pe_state, e_pe);
        check("a_out",    a_out,    e_aout);
        check("rdb_addr", rdb_addr, e_rdb);
        if (done === 1'b1) done_seen++;
    endtask

    // One clock: compare outputs, drive inputs, advance the model. Entered
    // and left at a falling edge.
    task automatic cycle(input logic st, input logic lw, input logic wv,
                         input logic [DW-1:0] wd, input logic [MN-1:0] wm,
                         input logic av, input logic [MN*DW-1:0] ad);
        compare_all();
        start = st; load_w = lw; w_valid = wv; w_data = wd; w_mask = wm;
        a_valid = av; a_data = ad;
        e_wrb = '0; e_pe = INVALID; e_done = 1'b0;
        case (ph)
            P_IDLE: if (st) begin
                ph = lw ? P_LOAD : P_STREAM;
                k  = 0;
            end
            P_LOAD: if (wv) begin
                e_wrb = wm; e_wdata = wd; e_waddr = AB'(k);
                k++;
                if (k == KL) begin k = 0; ph = P_STREAM; end
            end
            P_STREAM: if (av) begin
                e_aout = ad; e_rdb = AB'(k);
                e_pe = (k == KL - 1) ? CNN_FIN : VALID;
                k++;
                if (k == KL) begin k = 0; dc = 0; ph = P_DRAIN; end
            end
            default: begin
                e_aout = '0; e_rdb = '0;
                if (dc == DC) ph = P_IDLE;
                else begin
                    dc++;
                    e_done = (dc == DC);
                end
            end
        endcase
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    function automatic logic [MN*DW-1:0] lanes(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'h30 + b, 8'h20 + b, 8'h10 + b, b};
    endfunction

    // Directed pass. w_stall_at / a_bubble_at insert 3 / 2 idle cycles before
    // that beat index (-1 = none); noise drives start during LOAD and DRAIN.
    task automatic dir_pass(input logic lw, input logic [MN-1:0] m,
                            input int w_stall_at, input int a_bubble_at,
                            input logic noise);
        int d0;
        d0 = done_seen;
        cycle(1'b1, lw, 1'b0, '0, '0, 1'b0, '0);
        if (lw) begin
            for (int i = 0; i < KL; i++) begin
                if (i == w_stall_at) repeat (3) cycle(noise, 1'b1, 1'b0, '0, m, 1'b0, '0);
                cycle(noise, 1'b1, 1'b1, DW'(i + 1), m, 1'b0, '0);
            end
        end
        for (int i = 0; i < KL; i++) begin
            if (i == a_bubble_at) repeat (2) idle_cycle();
            cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, lanes(i));
        end
        repeat (DC + 1) cycle(noise, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        idle_cycle();
        check("done_per_pass", 64'(done_seen - d0), 64'd1);
    endtask

    task automatic rand_pass(input logic lw, input int p_w, input int p_a);
        int d0;
        int budget;
        d0 = done_seen;
        budget = 0;
        cycle(1'b1, lw, 1'b0, '0, '0, 1'b0, '0);
        while (ph != P_IDLE && budget < 2000) begin
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom),
                  1'($urandom_range(0, 99) < p_w), DW'($urandom), MN'($urandom),
                  1'($urandom_range(0, 99) < p_a), MN*DW'($urandom));
            budget++;
        end
        if (budget >= 2000) check("pass_timeout", 64'(budget), 64'd0);
        idle_cycle();
        check("done_per_pass", 64'(done_seen - d0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; load_w = 0; w_valid = 0; a_valid = 0;
        w_data = '0; w_mask = '0; a_data = '0;
        k1_start = 0; k1_load_w = 0; k1_w_valid = 0; k1_a_valid = 0;
        k1_w_data = '0; k1_w_mask = '0; k1_a_data = '0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            compare_all();
        end
        reset = 1'b0;
        idle_cycle();

        // 1. full pass, continuous valids, with starts in LOAD and DRAIN (6)
        dir_pass(1'b1, 4'b1111, -1, -1, 1'b1);
        // 2. activation bubbles after beat 2
        dir_pass(1'b1, 4'b1111, -1, 3, 1'b0);
        // 3. weight reuse
        dir_pass(1'b0, 4'b1111, -1, -1, 1'b0);
        // 4. partial mask and LOAD stall
        dir_pass(1'b1, 4'b0101, 4, -1, 1'b0);

        // 5. reset after STREAM beat 4
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < KL; i++) cycle(1'b0, 1'b0, 1'b1, DW'(8'hA0 + i), 4'b1111, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, lanes(i));
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        start = 0; w_valid = 0; a_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) idle_cycle();
        dir_pass(1'b1, 4'b1111, -1, -1, 1'b0);

        // randomized passes
        for (int r = 0; r < 12; r++) begin
            rand_pass((r == 0) ? 1'b1 : 1'($urandom), $urandom_range(30, 100),
                      $urandom_range(30, 100));
            repeat ($urandom_range(0, 3)) idle_cycle();
        end
        compare_all();

        // KERNEL_LEN = 1 boundary
        k1_start = 1; k1_load_w = 1;
        @(negedge clk);
        check("k1_w_ready", k1_w_ready, 1'b1);
        k1_start = 0; k1_w_valid = 1; k1_w_data = 8'h5A; k1_w_mask = 4'b1111;
        @(negedge clk);
        check("k1_wrb",      k1_wrb,      4'b1111);
        check("k1_wrb_addr", k1_wrb_addr, 4'd0);
        check("k1_wrb_data", k1_wrb_data, 8'h5A);
        check("k1_a_ready",  k1_a_ready,  1'b1);
        k1_w_valid = 0; k1_a_valid = 1; k1_a_data = 32'h11223344;
        @(negedge clk);
        check("k1_pe_state", k1_pe_state, CNN_FIN);
        check("k1_rdb_addr", k1_rdb_addr, 4'd0);
        check("k1_a_out",    k1_a_out,    32'h11223344);
        check("k1_wrb",      k1_wrb,      4'b0000);
        k1_a_valid = 0;
        for (int i = 1; i <= DC; i++) begin
            @(negedge clk);
            check("k1_pe_drain", k1_pe_state, INVALID);
            check("k1_done",     k1_done,     i == DC);
            check("k1_busy",     k1_busy,     1'b1);
        end
        @(negedge clk);
        check("k1_busy_end", k1_busy, 1'b0);
        check("k1_done_end", k1_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
